// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared quadrature phase encoding, emulator state enum and defaults
package quad_pkg;

  // {A,B} phase values; forward order is 00 -> 10 -> 11 -> 01 (A leads B)
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam int DEFAULT_CPR = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2
  } state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic logic [1:0] prev_phase(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - edge-rate timer that ticks once every max(period,1) clocks
module step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                clear,
  input  logic                hold,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] last;

  // terminal count; a zero period behaves like one so the tick fires every clock
  assign last = (period == '0) ? '0 : period - PERIOD_W'(1);
  // >= so a period shortened below the elapsed count fires on the next clock
  assign tick = (count >= last);

  // elapsed-clock counter: cleared by the owner or on tick, frozen while held
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)     count <= '0;
    else if (clear) count <= '0;
    else if (!hold) count <= tick ? '0 : count + PERIOD_W'(1);
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// rtl/quad_encoder_emulator.sv - quadrature A/B/index generator chasing a commanded position
module quad_encoder_emulator
  import quad_pkg::*;
#(
  parameter int POS_W    = 24,
  parameter int PERIOD_W = 16,
  parameter int CPR      = DEFAULT_CPR
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [POS_W-1:0] target,
  input  logic                    target_valid,
  input  logic [PERIOD_W-1:0]     step_period,
  input  logic                    load,
  input  logic signed [POS_W-1:0] load_value,
  output logic                    quadA,
  output logic                    quadB,
  output logic                    index,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [POS_W-1:0] CPR_W        = POS_W'(CPR);
  localparam logic signed [POS_W:0]   DIFF_ONE     = (POS_W+1)'(1);
  localparam logic signed [POS_W:0]   DIFF_NEG_ONE = '1;

  state_t                  state_q, state_d;
  logic [1:0]              phase_q, phase_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [POS_W-1:0] tgt_q, tgt_d, tgt_eff;
  logic signed [POS_W:0]   diff;
  logic                    dir_q, dir_d, want_fwd;
  logic                    done_d, timer_clear, tick;

  step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (timer_clear),
    .hold   (~enable),
    .period (step_period),
    .tick   (tick)
  );

  // a strobed target already steers the cycle it arrives in
  assign tgt_eff  = target_valid ? target : tgt_q;
  assign diff     = {tgt_eff[POS_W-1], tgt_eff} - {pos_q[POS_W-1], pos_q};
  assign want_fwd = ~diff[POS_W];

  // next state: load preset wins, else latch target, then move only while enabled
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pos_d       = pos_q;
    tgt_d       = tgt_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    timer_clear = 1'b0;
    if (load) begin
      pos_d       = load_value;
      tgt_d       = load_value;
      state_d     = IDLE;
      timer_clear = 1'b1;
    end else begin
      tgt_d = tgt_eff;
      if (enable) begin
        if (state_q == IDLE) begin
          timer_clear = 1'b1;
          if (diff != '0) begin
            state_d = RUN;
            dir_d   = want_fwd;
          end else if (target_valid) begin
            done_d = 1'b1;
          end
        end else if (diff == '0) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          timer_clear = 1'b1;
        end else if (want_fwd != dir_q) begin
          // reversal: hold the phase for a fresh full period before stepping back
          state_d     = DWELL;
          dir_d       = want_fwd;
          timer_clear = 1'b1;
        end else if (tick) begin
          pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          phase_d = dir_q ? next_phase(phase_q) : prev_phase(phase_q);
          if (diff == (dir_q ? DIFF_ONE : DIFF_NEG_ONE)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
    end
  end

  // state, position, phase and the registered status outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= PH_00;
      pos_q   <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b1;
      index   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      index   <= ((pos_d % CPR_W) == '0);
      busy    <= (state_d != IDLE);
      done    <= done_d;
    end
  end

  assign quadA    = phase_q[1];
  assign quadB    = phase_q[0];
  assign position = pos_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// tb/tb_quad_encoder_emulator.sv - directed and randomized checks of quad_encoder_emulator against a behavioural model
module tb_quad_encoder_emulator;

  localparam int POS_W    = 24;
  localparam int PERIOD_W = 16;
  localparam int CPR      = 4096;

  logic                    CLK = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    target_valid;
  logic                    load;
  logic signed [POS_W-1:0] target;
  logic signed [POS_W-1:0] load_value;
  logic [PERIOD_W-1:0]     step_period;
  logic                    quadA, quadB, index, busy, done;
  logic signed [POS_W-1:0] position;

  int vectors     = 0;
  int miscompares = 0;

  // behavioural model: plain integers
  int m_pos, m_tgt, m_dir, m_wait, m_edges;
  bit m_moving, m_done, m_loaded;

  // external quadrature counter driven only by the DUT's A/B lines
  int         qc_pos;
  logic [1:0] qc_prev;

  quad_encoder_emulator #(
    .POS_W    (POS_W),
    .PERIOD_W (PERIOD_W),
    .CPR      (CPR)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .enable       (enable),
    .target       (target),
    .target_valid (target_valid),
    .step_period  (step_period),
    .load         (load),
    .load_value   (load_value),
    .quadA        (quadA),
    .quadB        (quadB),
    .index        (index),
    .position     (position),
    .busy         (busy),
    .done         (done)
  );

  always #5 CLK = ~CLK;

  // {A,B} after k net forward edges from the reset phase
  function automatic logic [1:0] gray(input int k);
    case (((k % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] gray_next(input logic [1:0] ph);
    for (int k = 0; k < 4; k++)
      if (gray(k) == ph) return gray(k + 1);
    return ph;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_tgt = 0; m_dir = 1; m_wait = 0; m_edges = 0;
    m_moving = 0; m_done = 0; m_loaded = 0;
    qc_pos = 0; qc_prev = 2'b00;
  endtask

  // one clock of the spec rules, using the inputs present at the edge
  task automatic model_step();
    int d, eff, s;
    m_done   = 0;
    m_loaded = 0;
    if (load) begin
      m_pos = int'(load_value); m_tgt = m_pos; m_moving = 0; m_wait = 0; m_loaded = 1;
      return;
    end
    if (target_valid) m_tgt = int'(target);
    if (!enable) return;
    d   = m_tgt - m_pos;
    eff = (step_period == 0) ? 1 : int'(step_period);
    s   = (d > 0) ? 1 : -1;
    if (!m_moving) begin
      m_wait = 0;
      if (d != 0) begin m_moving = 1; m_dir = s; end
      else if (target_valid) m_done = 1;
    end else if (d == 0) begin
      m_moving = 0; m_done = 1; m_wait = 0;
    end else if (s != m_dir) begin
      m_dir = s; m_wait = 0;
    end else if (m_wait + 1 >= eff) begin
      m_pos += m_dir; m_edges += m_dir; m_wait = 0;
      if (m_pos == m_tgt) begin m_moving = 0; m_done = 1; end
    end else begin
      m_wait++;
    end
  endtask

  task automatic compare();
    logic [1:0] ab;
    ab = {quadA, quadB};
    chk("position", int'(position), m_pos);
    chk("quad_ab", int'(ab), int'(gray(m_edges)));
    chk("index", int'(index), int'((m_pos % CPR) == 0));
    chk("busy", int'(busy), int'(m_moving));
    chk("done", int'(done), int'(m_done));
    chk("quad_one_toggle", int'($countones(ab ^ qc_prev) <= 1), 1);
    if (ab == gray_next(qc_prev)) qc_pos++;
    else if (qc_prev == gray_next(ab)) qc_pos--;
    qc_prev = ab;
    if (m_loaded) qc_pos = m_pos;
    chk("closed_loop", qc_pos, int'(position));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare();
    target_valid = 1'b0;
    load         = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_position"}, int'(position), 0);
    chk({tag, "_quadA"}, int'(quadA), 0);
    chk({tag, "_quadB"}, int'(quadB), 0);
    chk({tag, "_index"}, int'(index), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int n, first, idx_hi, sv_pos, sv_ab;
    int rec_pos [3];
    int rec_ab  [3];

    reset = 1'b0; enable = 1'b0; target_valid = 1'b0; load = 1'b0;
    target = '0; load_value = '0; step_period = 16'd4;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_reset_values("reset");
    reset  = 1'b1;
    enable = 1'b1;

    // forward to +10 at period 4
    target = POS_W'(10); target_valid = 1'b1;
    n = 0; first = 0;
    do begin
      cycle(); n++;
      if (first == 0 && int'(position) != 0) first = n;
    end while (!done && n < 200);
    chk("t1_first_edge_cycle", first, 5);
    chk("t1_done_cycle", n, 41);
    chk("t1_final_position", int'(position), 10);
    cycle();
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_done_width", int'(done), 0);

    // reverse to -3 at period 1 from a fresh reset
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    step_period = 16'd1; target = POS_W'(-3); target_valid = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      rec_pos[k] = int'(position);
      rec_ab[k]  = int'({quadA, quadB});
    end
    chk("t2_pos0", rec_pos[0], -1);
    chk("t2_pos1", rec_pos[1], -2);
    chk("t2_pos2", rec_pos[2], -3);
    chk("t2_ab0", rec_ab[0], 1);
    chk("t2_ab1", rec_ab[1], 3);
    chk("t2_ab2", rec_ab[2], 2);
    chk("t2_done", int'(done), 1);

    // retarget across the current position mid-run
    load_value = '0; load = 1'b1;
    cycle();
    step_period = 16'd3; target = POS_W'(100); target_valid = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (int'(position) != 20 && n < 500);
    chk("t3_reached_20", int'(position), 20);
    target = POS_W'(5); target_valid = 1'b1;
    cycle();
    n = 0; first = 0;
    do begin
      cycle(); n++;
      if (first == 0 && int'(position) != 20) first = n;
    end while (!done && n < 500);
    chk("t3_first_reverse_cycle", first, 3);
    chk("t3_done_cycle", n, 45);
    chk("t3_final_position", int'(position), 5);

    // preset just below a revolution boundary, then cross it
    load_value = POS_W'(4095); load = 1'b1;
    cycle();
    chk("t4_load_position", int'(position), 4095);
    chk("t4_load_index", int'(index), 0);
    step_period = 16'd2; target = POS_W'(4097); target_valid = 1'b1;
    n = 0; idx_hi = 0;
    do begin
      cycle(); n++;
      if (index) idx_hi++;
    end while (!done && n < 100);
    chk("t4_index_cycles", idx_hi, 2);
    chk("t4_final_position", int'(position), 4097);

    // load and target strobe together: load wins
    load_value = POS_W'(7); load = 1'b1; target = POS_W'(50); target_valid = 1'b1;
    cycle();
    chk("t4b_load_position", int'(position), 7);
    chk("t4b_no_done", int'(done), 0);
    cycle();
    chk("t4b_stays_idle", int'(busy), 0);

    // freeze mid-run; a target strobed while frozen is still taken
    step_period = 16'd5; target = POS_W'(200); target_valid = 1'b1;
    repeat (20) cycle();
    enable = 1'b0;
    sv_pos = int'(position);
    sv_ab  = int'({quadA, quadB});
    for (int k = 0; k < 50; k++) begin
      if (k == 10) begin target = POS_W'(150); target_valid = 1'b1; end
      cycle();
    end
    chk("t5_frozen_position", int'(position), sv_pos);
    chk("t5_frozen_ab", int'({quadA, quadB}), sv_ab);
    enable = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!done && n < 2000);
    chk("t5_final_position", int'(position), 150);

    // asynchronous reset between clock edges
    step_period = 16'd2; target = POS_W'(300); target_valid = 1'b1;
    repeat (13) cycle();
    #2 reset = 1'b0;
    #1 chk_reset_values("t6_async");
    model_reset();
    @(negedge CLK);
    reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        target_valid = 1'b1;
        target = POS_W'(m_pos + int'($urandom_range(0, 80)) - 40);
      end
      if ($urandom_range(0, 49) == 0) begin
        load = 1'b1;
        load_value = POS_W'(m_pos + int'($urandom_range(0, 40)) - 20);
      end
      if ($urandom_range(0, 29) == 0) step_period = PERIOD_W'($urandom_range(0, 4));
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
